// File: rtl/axi_lite_reg_slave_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the register slave.
package axi_lite_reg_slave_pkg;

    localparam int RESP_OKAY   = 0;
    localparam int RESP_SLVERR = 2;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_HAVE_A = 2'd1,
        WR_HAVE_D = 2'd2,
        WR_RESP   = 2'd3
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8:0]   wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [RESP_WIDTH-1:0]   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [RESP_WIDTH-1:0]   rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave_reg_array.sv
// Register storage: byte-strobed synchronous write port, asynchronous read port, flat view.
module axi_reg_array #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [$clog2(NUM_REGS)-1:0]    widx_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic [$clog2(NUM_REGS)-1:0]    ridx_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb_i[b]) mem_d[widx_i][8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_REGS; k++) mem_q[k] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[ridx_i];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
    end
endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-bank slave: write and read FSMs plus address decode.
// Define AXI_REG_SLAVE_ERR_EN to answer out-of-window accesses with SLVERR instead of OKAY.
module axi_lite_reg_slave
    import axi_lite_reg_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int NUM_REGS   = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                           s0_axi_aclk,
    input  logic                           s0_axi_areset,
    axi_lite_reg_slave_if.slave            s0_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH/8;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   WIN  = (ADDR_WIDTH+1)'(4*NUM_REGS);
    localparam logic [RESP_WIDTH-1:0] OKAY = RESP_WIDTH'(RESP_OKAY);
`ifdef AXI_REG_SLAVE_ERR_EN
    localparam logic [RESP_WIDTH-1:0] OOR_RESP = RESP_WIDTH'(RESP_SLVERR);
`else
    localparam logic [RESP_WIDTH-1:0] OOR_RESP = RESP_WIDTH'(RESP_OKAY);
`endif

    wr_state_e               wr_state_q, wr_state_d;
    rd_state_e               rd_state_q, rd_state_d;
    logic                    live_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic [RESP_WIDTH-1:0]   bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, arr_regs;

    logic awready, wready, arready, aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
    logic [DATA_WIDTH-1:0] wr_data, arr_rdata;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_in_range, rd_in_range;

    assign awready = live_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_D);
    assign wready  = live_q && (wr_state_q == WR_IDLE || wr_state_q == WR_HAVE_A);
    assign arready = live_q && (rd_state_q == RD_IDLE);
    assign aw_hs   = s0_axi.awvalid && awready;
    assign w_hs    = s0_axi.wvalid && wready;
    assign ar_hs   = s0_axi.arvalid && arready;

    // Commit uses whichever half was latched earlier and the other half live from the bus.
    assign wr_addr = (wr_state_q == WR_HAVE_A) ? awaddr_q : s0_axi.awaddr;
    assign wr_data = (wr_state_q == WR_HAVE_D) ? wdata_q  : s0_axi.wdata;
    assign wr_strb = (wr_state_q == WR_HAVE_D) ? wstrb_q  : s0_axi.wstrb[STRB_W-1:0];
    assign wr_off  = wr_addr - BASE;
    assign rd_off  = s0_axi.araddr - BASE;
    assign wr_in_range = {1'b0, wr_off} < WIN;
    assign rd_in_range = {1'b0, rd_off} < WIN;

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        if (aw_hs) awaddr_d = s0_axi.awaddr;
        if (w_hs) begin
            wdata_d = s0_axi.wdata;
            wstrb_d = s0_axi.wstrb[STRB_W-1:0];
        end
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) commit = 1'b1;
                else if (aw_hs)    wr_state_d = WR_HAVE_A;
                else if (w_hs)     wr_state_d = WR_HAVE_D;
            end
            WR_HAVE_A: commit = w_hs;
            WR_HAVE_D: commit = aw_hs;
            WR_RESP:   if (s0_axi.bready) wr_state_d = WR_IDLE;
            default:   wr_state_d = WR_IDLE;
        endcase
        if (commit) begin
            wr_state_d = WR_RESP;
            bresp_d    = wr_in_range ? OKAY : OOR_RESP;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_DATA;
                    rdata_d    = rd_in_range ? arr_rdata : '0;
                    rresp_d    = rd_in_range ? OKAY : OOR_RESP;
                end
            end
            RD_DATA: if (s0_axi.rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
        if (s0_axi_areset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            live_q     <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            regs_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            live_q     <= 1'b1;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            regs_q     <= arr_regs;
        end
    end

    axi_reg_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regs (
        .clk_i   (s0_axi_aclk),
        .rst_i   (s0_axi_areset),
        .we_i    (commit && wr_in_range),
        .widx_i  (wr_off[IDX_W+1:2]),
        .wdata_i (wr_data),
        .wstrb_i (wr_strb),
        .ridx_i  (rd_off[IDX_W+1:2]),
        .rdata_o (arr_rdata),
        .regs_o  (arr_regs)
    );

    assign s0_axi.awready = awready;
    assign s0_axi.wready  = wready;
    assign s0_axi.arready = arready;
    assign s0_axi.bvalid  = (wr_state_q == WR_RESP);
    assign s0_axi.bresp   = bresp_q;
    assign s0_axi.rvalid  = (rd_state_q == RD_DATA);
    assign s0_axi.rresp   = rresp_q;
    assign s0_axi.rdata   = rdata_q;
    assign regs_out       = regs_q;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave (NUM_REGS=4, BASE_ADDR=0): directed cases then random traffic.
module tb_axi_lite_reg_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [127:0] regs_out;

    always #5 clk = ~clk;

    axi_lite_reg_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_WIDTH(3)) bus ();

    axi_lite_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .NUM_REGS(4), .BASE_ADDR(0)
    ) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_areset (rst),
        .s0_axi        (bus),
        .regs_out      (regs_out)
    );

`ifdef AXI_REG_SLAVE_ERR_EN
    localparam logic [2:0] OOR = 3'd2;
`else
    localparam logic [2:0] OOR = 3'd0;
`endif

    typedef struct { logic [31:0] data; logic [2:0] resp; } rexp_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [4];
    logic [2:0]  bexp [$];
    rexp_t       rexp [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever a response handshake is about to occur.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bvalid && bus.bready) begin
                if (bexp.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bresp", {61'd0, bus.bresp}, {61'd0, bexp.pop_front()});
            end
            if (bus.rvalid && bus.rready) begin
                if (rexp.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    rexp_t e;
                    e = rexp.pop_front();
                    chk("rdata", {32'd0, bus.rdata}, {32'd0, e.data});
                    chk("rresp", {61'd0, bus.rresp}, {61'd0, e.resp});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string nm);
        for (int k = 0; k < 4; k++) chk(nm, {32'd0, regs_out[k*32 +: 32]}, {32'd0, model[k]});
    endtask

    // bdly < 0: bready held high from the start; otherwise bready held low for bdly cycles of bvalid.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                            input int aw_at, input int w_at, input int bdly);
        logic [2:0] resp;
        logic aw_done, w_done, aw_go, w_go;
        int cyc;
        if (addr < 8'd16) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr / 4] = (model[addr / 4] & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
            resp = 3'd0;
        end else begin
            resp = OOR;
        end
        bexp.push_back(resp);
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.bready = (bdly < 0);
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.awvalid = !aw_done && (cyc >= aw_at);
            bus.wvalid  = !w_done && (cyc >= w_at);
            @(negedge clk);
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid && bus.wready;
            step();
            aw_done = aw_done | aw_go;
            w_done  = w_done | w_go;
            cyc++;
        end
        bus.awvalid = 0;
        bus.wvalid  = 0;
        chk("aw_w_accept", {63'd0, aw_done && w_done}, 64'd1);
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("bvalid_hold", {63'd0, bus.bvalid}, 64'd1);
            chk("bresp_hold", {61'd0, bus.bresp}, {61'd0, resp});
            chk("awready_busy", {63'd0, bus.awready}, 64'd0);
            chk("wready_busy", {63'd0, bus.wready}, 64'd0);
            step();
        end
        bus.bready = 1;
        @(negedge clk);
        chk("bvalid", {63'd0, bus.bvalid}, 64'd1);
        step();
        bus.bready = 0;
        @(negedge clk);
        chk("bvalid_drop", {63'd0, bus.bvalid}, 64'd0);
        check_regs("regs_out");
        step();
    endtask

    task automatic do_read(input logic [7:0] addr, input int rdly);
        rexp_t e;
        logic done, go;
        int cyc;
        e.data = (addr < 8'd16) ? model[addr / 4] : 32'd0;
        e.resp = (addr < 8'd16) ? 3'd0 : OOR;
        rexp.push_back(e);
        bus.araddr = addr;
        bus.rready = 0;
        done = 0; cyc = 0;
        while (!done && cyc < 40) begin
            bus.arvalid = 1;
            @(negedge clk);
            go = bus.arready;
            step();
            done = go;
            cyc++;
        end
        bus.arvalid = 0;
        chk("ar_accept", {63'd0, done}, 64'd1);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rvalid_hold", {63'd0, bus.rvalid}, 64'd1);
            chk("rdata_hold", {32'd0, bus.rdata}, {32'd0, e.data});
            chk("arready_busy", {63'd0, bus.arready}, 64'd0);
            step();
        end
        bus.rready = 1;
        @(negedge clk);
        chk("rvalid", {63'd0, bus.rvalid}, 64'd1);
        step();
        bus.rready = 0;
        @(negedge clk);
        chk("rvalid_drop", {63'd0, bus.rvalid}, 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        logic [7:0] a;
        for (int k = 0; k < 4; k++) model[k] = '0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        repeat (2) step();

        // Release reset: readies stay low until one edge later.
        rst = 0;
        @(negedge clk);
        chk("awready_rstcyc", {63'd0, bus.awready}, 64'd0);
        chk("wready_rstcyc", {63'd0, bus.wready}, 64'd0);
        chk("arready_rstcyc", {63'd0, bus.arready}, 64'd0);
        step();
        @(negedge clk);
        chk("awready_live", {63'd0, bus.awready}, 64'd1);
        chk("wready_live", {63'd0, bus.wready}, 64'd1);
        chk("arready_live", {63'd0, bus.arready}, 64'd1);
        chk("bvalid_rst", {63'd0, bus.bvalid}, 64'd0);
        chk("rvalid_rst", {63'd0, bus.rvalid}, 64'd0);
        check_regs("regs_rst");
        step();

        do_write(8'd0, 32'd56, 5'd15, 0, 0, -1);
        do_write(8'd4, 32'hA5A5A5A5, 5'd1, 2, 0, 3);
        do_write(8'd8, 32'd49, 5'h1F, 0, 1, 0);
        do_read(8'd8, 2);
        do_read(8'd16, 1);
        do_write(8'd16, 32'hDEADBEEF, 5'd15, 0, 0, 1);
        do_write(8'd12, 32'h12345678, 5'd0, 1, 0, 0);
        do_read(8'd3, 0);

        // Reset between AW and W: the held address is dropped and no response follows.
        bus.awaddr = 8'd0; bus.awvalid = 1;
        step();
        bus.awvalid = 0;
        rst = 1;
        for (int k = 0; k < 4; k++) model[k] = '0;
        step();
        rst = 0;
        bcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.bvalid) bcnt++;
            step();
        end
        chk("no_b_after_rst", 64'(bcnt), 64'd0);
        check_regs("regs_after_rst");
        do_read(8'd0, 0);

        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 5'($urandom_range(0, 31)),
                         $urandom_range(0, 2), $urandom_range(0, 2), int'($urandom_range(0, 4)) - 1);
            else
                do_read(a, $urandom_range(0, 3));
        end

        repeat (3) step();
        chk("bexp_empty", 64'(bexp.size()), 64'd0);
        chk("rexp_empty", 64'(rexp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
